// File: rtl/seq_pattern_gen_1010_pkg.sv
// Shared types and helpers for the serial pattern generator.
package seq_pattern_gen_1010_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   localparam logic [3:0] DEFAULT_PAT_C = 4'b1010;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_pattern_gen_1010_if.sv
// Request/serial-stream bundle between a requester (master) and the generator (slave).
interface seq_pattern_gen_1010_if #(
   parameter int WIDTH = 4,
   parameter int RW    = 4
);
   import seq_pattern_gen_1010_pkg::*;

   logic             start;
   logic             use_default;
   logic [WIDTH-1:0] pattern;
   logic [RW-1:0]    repeat_cnt;
   logic             x;
   logic             x_valid;
   logic             ready;
   logic             busy;
   logic             done;

   modport master (
      output start, use_default, pattern, repeat_cnt,
      input  x, x_valid, ready, busy, done
   );

   modport slave (
      input  start, use_default, pattern, repeat_cnt,
      output x, x_valid, ready, busy, done
   );

endinterface

// File: rtl/seq_pattern_gen_1010.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB-first,
// repeat_cnt+1 times with optional idle gaps, then pulses done.
module seq_pattern_gen_1010
   import seq_pattern_gen_1010_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter int               RW          = 4,
   parameter int               GAP         = 0,
   parameter logic [WIDTH-1:0] DEFAULT_PAT = WIDTH'(DEFAULT_PAT_C)
) (
   input  logic                  clk,
   input  logic                  rst,
   seq_pattern_gen_1010_if.slave gen_if
);

   localparam int BW = clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [RW-1:0]    copy_q, copy_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             gap_last;

   generate
      if (GAP > 0) begin : g_gap
         localparam int GW = clog2(GAP + 1);
         logic [GW-1:0] gap_q, gap_d;

         always_comb gap_d = (state_q == ST_GAP) ? gap_q + 1'b1 : '0;

         always_ff @(posedge clk) begin
            if (rst) gap_q <= '0;
            else     gap_q <= gap_d;
         end

         assign gap_last = (gap_q == GW'(GAP - 1));
      end else begin : g_nogap
         assign gap_last = 1'b1;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      pat_d   = pat_q;
      bit_d   = bit_q;
      copy_d  = copy_q;
      case (state_q)
         ST_IDLE, ST_FIN: begin
            if (gen_if.start) begin
               pat_d   = gen_if.use_default ? DEFAULT_PAT : gen_if.pattern;
               shreg_d = pat_d;
               copy_d  = gen_if.repeat_cnt;
               bit_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (bit_q == BW'(WIDTH - 1)) begin
               bit_d = '0;
               // copy_q counts copies still owed; only decremented while nonzero
               if (copy_q != '0) begin
                  copy_d = copy_q - 1'b1;
                  if (GAP > 0) state_d = ST_GAP;
                  else         shreg_d = pat_q;
               end else begin
                  state_d = ST_FIN;
               end
            end else begin
               bit_d   = bit_q + 1'b1;
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end
         end
         ST_GAP: begin
            if (gap_last) begin
               state_d = ST_SHIFT;
               shreg_d = pat_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      x_valid_d = (state_d == ST_SHIFT);
      x_d       = x_valid_d & shreg_d[WIDTH-1];
      busy_d    = (state_d == ST_SHIFT) || (state_d == ST_GAP);
      ready_d   = (state_d == ST_IDLE) || (state_d == ST_FIN);
      done_d    = (state_d == ST_FIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_q     <= '0;
         copy_q    <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_q     <= bit_d;
         copy_q    <= copy_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
      pat_q   <= pat_d;
   end

   assign gen_if.x       = x_q;
   assign gen_if.x_valid = x_valid_q;
   assign gen_if.busy    = busy_q;
   assign gen_if.ready   = ready_q;
   assign gen_if.done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen_1010.sv
// Directed bench for seq_pattern_gen_1010: table-driven run on a GAP=0 instance
// plus hand sequences for a GAP=2 instance and an RW=2 instance.
module tb_seq_pattern_gen_1010;

   localparam logic [4:0] S1  = 5'b11100;  // {x, x_valid, busy, ready, done}
   localparam logic [4:0] S0  = 5'b01100;
   localparam logic [4:0] IDL = 5'b00010;
   localparam logic [4:0] FN  = 5'b00011;

   typedef struct {
      logic       rst;
      logic       start;
      logic       use_default;
      logic [3:0] pattern;
      logic [3:0] rc;
      logic [4:0] exp;
      logic       det_chk;
      int         det_exp;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   hits;
   int   fill;
   logic [3:0] hist;
   vec_t vecs[$];

   seq_pattern_gen_1010_if #(.WIDTH(4), .RW(4)) a_if ();
   seq_pattern_gen_1010_if #(.WIDTH(4), .RW(4)) b_if ();
   seq_pattern_gen_1010_if #(.WIDTH(4), .RW(2)) c_if ();

   seq_pattern_gen_1010 #(.WIDTH(4), .RW(4), .GAP(0)) dut_a (.clk(clk), .rst(rst), .gen_if(a_if));
   seq_pattern_gen_1010 #(.WIDTH(4), .RW(4), .GAP(2)) dut_b (.clk(clk), .rst(rst), .gen_if(b_if));
   seq_pattern_gen_1010 #(.WIDTH(4), .RW(2), .GAP(0)) dut_c (.clk(clk), .rst(rst), .gen_if(c_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%b want=%b (x,x_valid,busy,ready,done)", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic s, input logic d, input logic [3:0] p,
                               input logic [3:0] rc, input logic [4:0] e,
                               input logic dc = 1'b0, input int de = 0);
      vec_t v;
      v.rst = r; v.start = s; v.use_default = d; v.pattern = p; v.rc = rc;
      v.exp = e; v.det_chk = dc; v.det_exp = de;
      vecs.push_back(v);
   endfunction

   initial begin
      logic [9:0] bx;
      logic [9:0] bv;
      logic [3:0] patv;
      logic [4:0] e;
      int busy_cnt;
      int done_cnt;
      int vld_cnt;

      checks = 0; failures = 0; hits = 0; fill = 0; hist = '0;
      rst = 1'b1;
      a_if.start = 1'b0; a_if.use_default = 1'b0; a_if.pattern = '0; a_if.repeat_cnt = '0;
      b_if.start = 1'b0; b_if.use_default = 1'b0; b_if.pattern = '0; b_if.repeat_cnt = '0;
      c_if.start = 1'b0; c_if.use_default = 1'b0; c_if.pattern = '0; c_if.repeat_cnt = '0;

      // Scenario 1: default pattern, single copy
      add(1, 0, 0, 4'h0, 4'd0, IDL);
      add(1, 0, 0, 4'h0, 4'd0, IDL);
      add(0, 1, 1, 4'h0, 4'd0, S1);
      add(0, 0, 0, 4'h0, 4'd0, S0);
      add(0, 0, 0, 4'h0, 4'd0, S1);
      add(0, 0, 0, 4'h0, 4'd0, S0);
      add(0, 0, 0, 4'h0, 4'd0, FN);
      add(0, 0, 0, 4'h0, 4'd0, IDL, 1'b1, 1);
      // Scenario 2: three back-to-back copies of 1010
      add(0, 1, 0, 4'b1010, 4'd2, S1);
      for (int i = 1; i < 12; i++) add(0, 0, 0, 4'h0, 4'd0, (i % 2 != 0) ? S0 : S1);
      add(0, 0, 0, 4'h0, 4'd0, FN);
      add(0, 0, 0, 4'h0, 4'd0, IDL, 1'b1, 5);
      // Scenario 4: start while busy ignored; start held through FIN accepted
      add(0, 1, 0, 4'b1010, 4'd0, S1);
      add(0, 1, 0, 4'b0110, 4'd0, S0);
      add(0, 0, 0, 4'b0110, 4'd0, S1);
      add(0, 1, 0, 4'b0110, 4'd0, S0);
      add(0, 1, 0, 4'b0110, 4'd0, FN);
      add(0, 1, 0, 4'b0110, 4'd0, S0);
      add(0, 0, 0, 4'h0, 4'd0, S1);
      add(0, 0, 0, 4'h0, 4'd0, S1);
      add(0, 0, 0, 4'h0, 4'd0, S0);
      add(0, 0, 0, 4'h0, 4'd0, FN);
      add(0, 0, 0, 4'h0, 4'd0, IDL, 1'b1, 1);
      // Scenario 5: reset during the second bit, then a clean default run
      add(0, 1, 1, 4'h0, 4'd0, S1);
      add(0, 0, 0, 4'h0, 4'd0, S0);
      add(1, 0, 0, 4'h0, 4'd0, IDL);
      add(0, 0, 0, 4'h0, 4'd0, IDL);
      add(0, 1, 1, 4'h0, 4'd0, S1);
      add(0, 0, 0, 4'h0, 4'd0, S0);
      add(0, 0, 0, 4'h0, 4'd0, S1);
      add(0, 0, 0, 4'h0, 4'd0, S0);
      add(0, 0, 0, 4'h0, 4'd0, FN);
      add(0, 0, 0, 4'h0, 4'd0, IDL, 1'b1, 1);

      repeat (2) @(posedge clk);
      #1;
      check5("rst_a", {a_if.x, a_if.x_valid, a_if.busy, a_if.ready, a_if.done}, IDL);
      check5("rst_b", {b_if.x, b_if.x_valid, b_if.busy, b_if.ready, b_if.done}, IDL);
      check5("rst_c", {c_if.x, c_if.x_valid, c_if.busy, c_if.ready, c_if.done}, IDL);

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         a_if.start = vecs[i].start;
         a_if.use_default = vecs[i].use_default;
         a_if.pattern = vecs[i].pattern;
         a_if.repeat_cnt = vecs[i].rc;
         @(posedge clk);
         #1;
         check5($sformatf("A_vec%0d", i),
                {a_if.x, a_if.x_valid, a_if.busy, a_if.ready, a_if.done}, vecs[i].exp);
         // Valid-gated overlapping 1010 detector fed from the serial stream
         if (a_if.x_valid === 1'b1) begin
            hist = {hist[2:0], a_if.x};
            fill = fill + 1;
            if (fill >= 4 && hist == 4'b1010) hits = hits + 1;
         end else begin
            hist = '0;
            fill = 0;
         end
         if (vecs[i].det_chk) begin
            check_int($sformatf("A_det%0d", i), hits, vecs[i].det_exp);
            hits = 0;
         end
      end
      rst = 1'b0;
      a_if.start = 1'b0;

      // GAP=2 instance: 1100, two idle cycles, 1100
      bx = 10'b1100001100;
      bv = 10'b1111001111;
      busy_cnt = 0;
      b_if.start = 1'b1; b_if.use_default = 1'b0; b_if.pattern = 4'b1100; b_if.repeat_cnt = 4'd1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         b_if.start = 1'b0;
         if (k <= 10)      e = {bx[10-k], bv[10-k], 3'b100};
         else if (k == 11) e = FN;
         else              e = IDL;
         check5($sformatf("B_cyc%0d", k), {b_if.x, b_if.x_valid, b_if.busy, b_if.ready, b_if.done}, e);
         if (b_if.busy === 1'b1) busy_cnt = busy_cnt + 1;
      end
      check_int("B_busy_cycles", busy_cnt, 10);

      // RW=2 instance at maximum repeat count: four copies of 1001
      patv = 4'b1001;
      done_cnt = 0;
      vld_cnt = 0;
      c_if.start = 1'b1; c_if.use_default = 1'b0; c_if.pattern = 4'b1001; c_if.repeat_cnt = 2'd3;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         c_if.start = 1'b0;
         if (k <= 16)      e = {patv[3 - ((k - 1) % 4)], 4'b1100};
         else if (k == 17) e = FN;
         else              e = IDL;
         check5($sformatf("C_cyc%0d", k), {c_if.x, c_if.x_valid, c_if.busy, c_if.ready, c_if.done}, e);
         if (c_if.done === 1'b1) done_cnt = done_cnt + 1;
         if (c_if.x_valid === 1'b1) vld_cnt = vld_cnt + 1;
      end
      check_int("C_done_pulses", done_cnt, 1);
      check_int("C_valid_bits", vld_cnt, 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
